aes_core_s3_top: RTL and testbench
==================================

// Module: aes_core_s3_top
// PURPOSE
//  Third AES-128 encryption stage: executes full rounds 6..9 (SubBytes, ShiftRows, MixColumns, AddRoundKey).
//  Sits directly downstream of aes_core_s2_top; its input job is that stage's forwarded state plus keys K6..K9.
//  A job is one 128-bit state plus four 128-bit round keys (K6..K9).
//  - Job arrives either serialized on consumer_data or in parallel on data_forward_out.
//  - Result leaves either serialized on producer_data or in parallel on data_forward_in.
//  Iterative datapath: one round per cycle, 16 shared aes_sbox instances (8b in/out, combinational).
// PARAMETERS
//  NUM_ROUNDS   4    rounds executed per job (K6..K9); round counter is $clog2(NUM_ROUNDS)+1 bits
//  BEAT_W       64   serial beat width on consumer_data/producer_data
// PORTS
//  clk                    in   1      clock
//  rst_n                  in   1      reset: synchronous, active low
//  acc_config             in   acc_pkg::acc_config_t  uncached config; unused, reserved
//  consumer_data.valid    in   1      serial job beat valid
//  consumer_data.ready    out  1      serial job beat accepted
//  consumer_data.data     in   64     beat order: S[127:64],S[63:0],K6 hi,K6 lo,...,K9 hi,K9 lo
//  producer_data.valid    out  1      serial result beat valid
//  producer_data.ready    in   1      downstream accepts beat
//  producer_data.data     out  64     beat 0 = R[127:64], beat 1 = R[63:0]; 0 when valid=0
//  data_forward_out.rdy   in   1      one-cycle pulse: upstream job words present
//  data_forward_out.data  in   5x128  [0]=state, [1..4]=K6..K9
//  data_forward_in.rdy    out  1      one-cycle pulse: result valid on data_forward_in.data[0]
//  data_forward_in.data   out  128    [0]=result register R (held until next job result)
//  bypass_control         in   3      [1]=1 serial input / 0 forward input; [0]=1 serial output / 0 forward; [2] unused
// BEHAVIOUR
//  Byte order: state[127:120] = byte 0, column-major per FIPS-197.
//  Reset: state IDLE; S, K6..K9, R, beat counter, round counter = 0.
//  Reset outputs: consumer_data.ready, producer_data.valid, data_forward_in.rdy all 0.
//  Reset while busy: job is discarded; nothing is emitted.
//  bypass_control[1:0] is latched on IDLE exit. Changes mid-job take effect on the next job.
//  FSM states: IDLE, LOAD, COMPUTE, EMIT, FWD.
//  IDLE:
//   - bypass[1]=1 and consumer_data.valid: go to LOAD; no beat is consumed in this cycle.
//   - bypass[1]=0 and data_forward_out.rdy: capture all 5 words in the same cycle, go to COMPUTE, round counter=0.
//   - Both inputs are gated by bypass[1]; the unselected source is ignored.
//  LOAD:
//   - consumer_data.ready=1.
//   - Each valid&ready beat is stored at its beat index and the beat counter increments.
//   - The handshake of beat 9 goes to COMPUTE with round counter=0.
//   - valid low: hold with no progress.
//  COMPUTE: each cycle S <= MixColumns(ShiftRows(SubBytes(S))) ^ K[6+rc], rc++.
//   - After rc=NUM_ROUNDS-1: R <= new S; go to EMIT if bypass[0]=1, else FWD.
//   - Latency is exactly NUM_ROUNDS cycles in COMPUTE.
//  EMIT:
//   - producer_data.valid=1, data=beat[cnt].
//   - Data is held stable while ready=0.
//   - The handshake of beat 1 goes to IDLE; the next job can start the following cycle.
//  FWD: data_forward_in.rdy=1 for exactly one cycle, then IDLE.
//  consumer_data.ready=0 outside LOAD. A forward rdy pulse outside IDLE is dropped (upstream must not issue one).
//  The round counter never wraps; counters clear on IDLE exit.
// TESTING
//  T1 serial in/out, S=0, K6..K9=0:
//   - 10 beats accepted; exactly 4 COMPUTE cycles.
//   - Out beats 0x7676767676767676 x2.
//  T2 forward in/out:
//   - data[0]=0, K6=all 0xff, K7..K9=0, rdy pulse.
//   - Exactly 4 cycles later data_forward_in.rdy pulses once with data[0]=0xa4 repeated x16.
//  T3 back-pressure:
//   - T1 with consumer valid toggling 50% and producer ready low for 5 cycles per beat.
//   - Same result; producer data stable while stalled; no beat lost or duplicated.
//  T4 bypass change mid-job:
//   - Start T1 serially, flip bypass_control[0] to 0 during LOAD.
//   - Output is still serial; the next job uses FWD.
//  T5 sync reset mid-COMPUTE:
//   - rst_n low 1 cycle at rc=2.
//   - Next cycle: IDLE, all outputs 0, no emit; a following T1 job passes.
//  T6 back-to-back:
//   - Two forward jobs with rdy pulses each issued in the first IDLE cycle available.
//   - Two results in order, no overlap.

Source files
------------

// File: rtl/aes_core_s3_top.sv
// AES-128 encryption rounds 6..9. The core computes one full round per cycle.
// Jobs and results move either as 64-bit serial beats or as parallel forward words.
package acc_pkg;
    typedef struct packed {
        logic        enable;
        logic [30:0] reserved;
    } acc_config_t;
endpackage

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 occupies the most significant byte of the table, so index by ~i_byte.
    logic [10:0] w_idx;
    assign w_idx  = {~i_byte, 3'b000};
    assign o_byte = SBOX_TABLE[w_idx +: 8];
endmodule

module aes_core_s3_top #(
    parameter int NUM_ROUNDS = 4,
    parameter int BEAT_W     = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  acc_pkg::acc_config_t            i_acc_config,
    input  logic                            i_consumer_data_valid,
    output logic                            o_consumer_data_ready,
    input  logic [BEAT_W-1:0]               i_consumer_data_data,
    output logic                            o_producer_data_valid,
    input  logic                            i_producer_data_ready,
    output logic [BEAT_W-1:0]               o_producer_data_data,
    input  logic                            i_data_forward_out_rdy,
    input  logic [(NUM_ROUNDS+1)*128-1:0]   i_data_forward_out_data,
    output logic                            o_data_forward_in_rdy,
    output logic [127:0]                    o_data_forward_in_data,
    input  logic [2:0]                      i_bypass_control
);
    localparam int NUM_WORDS = NUM_ROUNDS + 1;
    localparam int BPW       = 128 / BEAT_W;
    localparam int NUM_BEATS = NUM_WORDS * BPW;
    localparam int CNT_W     = $clog2(NUM_BEATS);
    localparam int RC_W      = $clog2(NUM_ROUNDS) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMPUTE,
        ST_EMIT,
        ST_FWD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_word [NUM_WORDS];
    logic [127:0]       r_result;
    logic [CNT_W-1:0]   r_cnt;
    logic [RC_W-1:0]    r_rc;
    logic [1:0]         r_bypass;

    logic [7:0]         w_sb [16];
    logic [7:0]         w_sr [16];
    logic [127:0]       w_mix;
    logic [127:0]       w_key;
    logic [127:0]       w_round;
    logic               w_last_beat;
    logic               w_last_round;
    logic               w_unused;

    assign w_unused = ^{i_acc_config, i_bypass_control[2]};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        aes_sbox u_sbox (
            .i_byte (r_word[0][127-8*gi -: 8]),
            .o_byte (w_sb[gi])
        );
    end

    // ShiftRows rotates row r left by r columns; bytes are column-major (index 4*col+row).
    always_comb begin
        w_mix = '0;
        for (int i = 0; i < 16; i++) begin
            w_sr[i] = w_sb[4 * (((i / 4) + (i % 4)) % 4) + (i % 4)];
        end
        for (int c = 0; c < 4; c++) begin
            w_mix[127-8*(4*c+0) -: 8] = xtime(w_sr[4*c]) ^ xtime(w_sr[4*c+1]) ^ w_sr[4*c+1]
                                      ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mix[127-8*(4*c+1) -: 8] = w_sr[4*c] ^ xtime(w_sr[4*c+1]) ^ xtime(w_sr[4*c+2])
                                      ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            w_mix[127-8*(4*c+2) -: 8] = w_sr[4*c] ^ w_sr[4*c+1] ^ xtime(w_sr[4*c+2])
                                      ^ xtime(w_sr[4*c+3]) ^ w_sr[4*c+3];
            w_mix[127-8*(4*c+3) -: 8] = xtime(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1]
                                      ^ w_sr[4*c+2] ^ xtime(w_sr[4*c+3]);
        end
    end

    always_comb begin
        w_key = r_word[1];
        for (int k = 0; k < NUM_ROUNDS; k++) begin
            if (r_rc == RC_W'(k)) w_key = r_word[k+1];
        end
    end

    assign w_round      = w_mix ^ w_key;
    assign w_last_beat  = (r_cnt == CNT_W'(NUM_BEATS - 1));
    assign w_last_round = (r_rc == RC_W'(NUM_ROUNDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt           = r_state;
        o_consumer_data_ready = 1'b0;
        o_producer_data_valid = 1'b0;
        o_data_forward_in_rdy = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_bypass_control[1]) begin
                    if (i_consumer_data_valid) w_state_nxt = ST_LOAD;
                end else if (i_data_forward_out_rdy) begin
                    w_state_nxt = ST_COMPUTE;
                end
            end
            ST_LOAD: begin
                o_consumer_data_ready = 1'b1;
                if (i_consumer_data_valid && w_last_beat) w_state_nxt = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (w_last_round) w_state_nxt = r_bypass[0] ? ST_EMIT : ST_FWD;
            end
            ST_EMIT: begin
                o_producer_data_valid = 1'b1;
                if (i_producer_data_ready && r_cnt == CNT_W'(BPW - 1)) w_state_nxt = ST_IDLE;
            end
            ST_FWD: begin
                o_data_forward_in_rdy = 1'b1;
                w_state_nxt           = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Word 0 is the working state S; words 1..NUM_ROUNDS hold the round keys.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int w = 0; w < NUM_WORDS; w++) r_word[w] <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_rc     <= '0;
            r_bypass <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_state_nxt != ST_IDLE) begin
                        r_bypass <= i_bypass_control[1:0];
                        r_cnt    <= '0;
                        r_rc     <= '0;
                        if (!i_bypass_control[1]) begin
                            for (int w = 0; w < NUM_WORDS; w++)
                                r_word[w] <= i_data_forward_out_data[w*128 +: 128];
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_consumer_data_valid) begin
                        for (int w = 0; w < NUM_WORDS; w++) begin
                            for (int s = 0; s < BPW; s++) begin
                                if (r_cnt == CNT_W'(w * BPW + s))
                                    r_word[w][128 - BEAT_W*(s+1) +: BEAT_W] <= i_consumer_data_data;
                            end
                        end
                        r_cnt <= w_last_beat ? '0 : r_cnt + 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    r_word[0] <= w_round;
                    r_rc      <= r_rc + 1'b1;
                    if (w_last_round) begin
                        r_result <= w_round;
                        r_cnt    <= '0;
                    end
                end
                ST_EMIT: begin
                    if (i_producer_data_ready) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_producer_data_data = '0;
        if (r_state == ST_EMIT) begin
            for (int s = 0; s < BPW; s++) begin
                if (r_cnt == CNT_W'(s))
                    o_producer_data_data = r_result[128 - BEAT_W*(s+1) +: BEAT_W];
            end
        end
    end

    assign o_data_forward_in_data = r_result;
endmodule

// File: tb/tb_aes_core_s3_top.sv
// Randomized bench for aes_core_s3_top. It checks the core against a GF(2^8)-based
// AES round model for serial and forward paths, back-pressure, reset and bypass latching.
module tb_aes_core_s3_top;
    localparam int NR = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    acc_pkg::acc_config_t  acc_cfg;
    logic                  cons_valid;
    logic                  cons_ready;
    logic [63:0]           cons_data;
    logic                  prod_valid;
    logic                  prod_ready;
    logic [63:0]           prod_data;
    logic                  fwd_out_rdy;
    logic [5*128-1:0]      fwd_out_data;
    logic                  fwd_in_rdy;
    logic [127:0]          fwd_in_data;
    logic [2:0]            bypass;

    int                    n_checks = 0;
    int                    n_fail   = 0;
    logic [7:0]            sbox_m [256];
    logic [127:0]          job [5];

    always #5 clk = ~clk;

    aes_core_s3_top dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .i_acc_config            (acc_cfg),
        .i_consumer_data_valid   (cons_valid),
        .o_consumer_data_ready   (cons_ready),
        .i_consumer_data_data    (cons_data),
        .o_producer_data_valid   (prod_valid),
        .i_producer_data_ready   (prod_ready),
        .o_producer_data_data    (prod_data),
        .i_data_forward_out_rdy  (fwd_out_rdy),
        .i_data_forward_out_data (fwd_out_data),
        .o_data_forward_in_rdy   (fwd_in_rdy),
        .o_data_forward_in_data  (fwd_in_data),
        .i_bypass_control        (bypass)
    );

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = (v << n) | (v >> (8 - n));
        return r;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [7:0] mc_coef(input int d);
        return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
    endfunction

    function automatic logic [127:0] model_result();
        logic [127:0] st;
        logic [127:0] nx;
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   acc;
        st = job[0];
        for (int rd = 0; rd < NR; rd++) begin
            for (int i = 0; i < 16; i++) b[i] = sbox_m[st[127-8*i -: 8]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c+r] = b[4*((c+r)%4)+r];
            nx = '0;
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++) acc ^= gf_mul(mc_coef((j - r + 4) % 4), t[4*c+j]);
                    nx[127-8*(4*c+r) -: 8] = acc;
                end
            end
            st = nx ^ job[rd+1];
        end
        return st;
    endfunction

    task automatic new_job();
        for (int w = 0; w < 5; w++) job[w] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic send_serial(input bit toggle, input int flip_at);
        int idx   = 0;
        int guard = 0;
        while (idx < 10 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (idx == flip_at) bypass = 3'b010;
            cons_valid = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            if (cons_valid) cons_data = (idx % 2 == 0) ? job[idx/2][127:64] : job[idx/2][63:0];
            else            cons_data = {$urandom, $urandom};
            if (cons_valid && cons_ready) idx++;
        end
        check_eq("load_beats", 128'(idx), 128'(10));
        @(negedge clk);
        cons_valid = 1'b0;
        check_eq("ready_after_load", 128'(cons_ready), 128'(0));
    endtask

    // Latency counts negedges from the first COMPUTE cycle until the output appears.
    task automatic recv_serial(input bit stall, input logic [127:0] exp);
        int          waits = 0;
        int          b     = 0;
        int          st    = 0;
        int          guard = 0;
        logic [63:0] got [2];
        logic [63:0] held;
        prod_ready = 1'b0;
        while (!prod_valid && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check_eq("emit_latency", 128'(waits), 128'(4));
        held = prod_data;
        while (b < 2 && guard < 200) begin
            guard++;
            if (!prod_valid) begin
                prod_ready = 1'b0;
            end else if (stall && st < 5) begin
                if (st == 0) held = prod_data;
                else         check_eq("stall_stable", 128'(prod_data), 128'(held));
                prod_ready = 1'b0;
                st++;
            end else begin
                if (stall) check_eq("stall_stable", 128'(prod_data), 128'(held));
                got[b]     = prod_data;
                prod_ready = 1'b1;
                b++;
                st = 0;
            end
            @(negedge clk);
        end
        prod_ready = 1'b0;
        check_eq("emit_beats", 128'(b), 128'(2));
        check_eq("serial_result", {got[0], got[1]}, exp);
        check_eq("emit_done_valid", 128'(prod_valid), 128'(0));
        check_eq("emit_done_data", 128'(prod_data), 128'(0));
    endtask

    task automatic send_fwd();
        @(negedge clk);
        check_eq("fwd_rdy_low", 128'(fwd_in_rdy), 128'(0));
        fwd_out_rdy  = 1'b1;
        fwd_out_data = {job[4], job[3], job[2], job[1], job[0]};
        @(negedge clk);
        fwd_out_rdy  = 1'b0;
        fwd_out_data = {5{$urandom, $urandom, $urandom, $urandom}};
    endtask

    task automatic wait_fwd(input logic [127:0] exp);
        int waits = 0;
        while (!fwd_in_rdy && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        check_eq("fwd_latency", 128'(waits), 128'(4));
        check_eq("fwd_result", fwd_in_data, exp);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [127:0] exp_a;
        logic [127:0] exp_b;
        int           seen;
        bit [1:0]     mode;

        build_sbox();
        acc_cfg      = '0;
        rst_n        = 1'b0;
        cons_valid   = 1'b0;
        cons_data    = '0;
        prod_ready   = 1'b0;
        fwd_out_rdy  = 1'b0;
        fwd_out_data = '0;
        bypass       = 3'b011;
        repeat (3) @(negedge clk);
        check_eq("rst_cons_ready", 128'(cons_ready), 128'(0));
        check_eq("rst_prod_valid", 128'(prod_valid), 128'(0));
        check_eq("rst_prod_data", 128'(prod_data), 128'(0));
        check_eq("rst_fwd_rdy", 128'(fwd_in_rdy), 128'(0));
        check_eq("rst_fwd_data", fwd_in_data, 128'(0));
        rst_n = 1'b1;

        // T1: serial in/out, all-zero job
        for (int w = 0; w < 5; w++) job[w] = '0;
        bypass = 3'b011;
        send_serial(1'b0, -1);
        recv_serial(1'b0, {16{8'h76}});

        // T2: forward in/out, K6 all ones
        for (int w = 0; w < 5; w++) job[w] = '0;
        job[1] = {128{1'b1}};
        bypass = 3'b000;
        send_fwd();
        wait_fwd({16{8'ha4}});

        // T3: back-pressure on both sides
        for (int w = 0; w < 5; w++) job[w] = '0;
        bypass = 3'b011;
        send_serial(1'b1, -1);
        recv_serial(1'b1, {16{8'h76}});

        // T4: output select flipped during LOAD applies to the next job only
        new_job();
        bypass = 3'b011;
        send_serial(1'b0, 3);
        recv_serial(1'b0, model_result());
        new_job();
        send_serial(1'b0, -1);
        wait_fwd(model_result());

        // T5: reset while rc=2
        for (int w = 0; w < 5; w++) job[w] = '0;
        bypass = 3'b011;
        send_serial(1'b0, -1);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("t5_cons_ready", 128'(cons_ready), 128'(0));
        check_eq("t5_prod_valid", 128'(prod_valid), 128'(0));
        check_eq("t5_fwd_rdy", 128'(fwd_in_rdy), 128'(0));
        check_eq("t5_fwd_data", fwd_in_data, 128'(0));
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (prod_valid || fwd_in_rdy) seen++;
        end
        check_eq("t5_no_emit", 128'(seen), 128'(0));
        send_serial(1'b0, -1);
        recv_serial(1'b0, {16{8'h76}});

        // T6: back-to-back forward jobs
        bypass = 3'b000;
        new_job();
        exp_a = model_result();
        send_fwd();
        wait_fwd(exp_a);
        new_job();
        exp_b = model_result();
        send_fwd();
        wait_fwd(exp_b);
        @(negedge clk);
        check_eq("t6_single_pulse", 128'(fwd_in_rdy), 128'(0));

        // Random jobs across all input/output path combinations
        for (int n = 0; n < 10; n++) begin
            new_job();
            exp_a  = model_result();
            mode   = 2'($urandom_range(0, 3));
            bypass = {1'b0, mode};
            if (mode[1]) send_serial(1'($urandom_range(0, 1)), -1);
            else         send_fwd();
            if (mode[0]) recv_serial(1'($urandom_range(0, 1)), exp_a);
            else         wait_fwd(exp_a);
        end
        @(negedge clk);
        check_eq("final_fwd_rdy", 128'(fwd_in_rdy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
